// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: drains the activation FIFO one N_ROWS-wide vector per cycle
// and feeds the systolic array's west edge. Row r is delayed r cycles relative
// to row 0, so each vector enters the array as a diagonal wavefront. A small
// FSM counts the programmed tile length and flushes the skew chains. It pulses
// done once the last vector's final row element has entered the array.
module sa_skew_feeder #(
   parameter int N_ROWS = 4,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [LEN_W-1:0]         tile_len,
   input  logic                     fifo_empty,
   input  logic [N_ROWS*DATA_W-1:0] fifo_data,
   output logic                     fifo_rd_en,
   input  logic                     stall,
   output logic [N_ROWS*DATA_W-1:0] sa_data,
   output logic [N_ROWS-1:0]        sa_valid,
   output logic                     busy,
   output logic                     done
);

   // The drain counter only has to hold N_ROWS-1.
   localparam int DRN_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t             state;
   logic [LEN_W-1:0]   remaining;
   logic [DRN_W-1:0]   drain_cnt;
   logic               adv;
   logic               pop;

   // The pipeline moves whenever the array is not pushing back. A pop is
   // only allowed when the pipeline moves, so a stalled vector stays in the FIFO.
   assign adv        = ~stall;
   assign pop        = (state == STREAM) & ~fifo_empty & adv & ~rst;
   assign fifo_rd_en = pop;

   // Tile sequencing. The FSM leaves STREAM on the final pop, so remaining
   // never decrements past zero. busy and done are registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
         drain_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (tile_len != '0) begin
                     remaining <= tile_len;
                     state     <= STREAM;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (pop) begin
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     if (N_ROWS > 1) begin
                        drain_cnt <= DRN_W'(N_ROWS - 1);
                        state     <= DRAIN;
                     end else begin
                        state <= DONE;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            DRAIN: begin
               if (adv) begin
                  drain_cnt <= drain_cnt - DRN_W'(1);
                  if (drain_cnt == DRN_W'(1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   for (genvar r = 0; r < N_ROWS; r++) begin : g_row
      logic [DATA_W-1:0] d_q [0:r];
      logic              v_q [0:r];

      // Row r shift chain of depth r+1. Stage 0 takes the popped element or a
      // zero bubble, and the last stage drives the west edge directly.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int k = 0; k <= r; k++) begin
               d_q[k] <= '0;
               v_q[k] <= 1'b0;
            end
         end else if (adv) begin
            d_q[0] <= pop ? fifo_data[r*DATA_W +: DATA_W] : '0;
            v_q[0] <= pop;
            for (int k = 1; k <= r; k++) begin
               d_q[k] <= d_q[k-1];
               v_q[k] <= v_q[k-1];
            end
         end
      end

      assign sa_data[r*DATA_W +: DATA_W] = d_q[r];
      assign sa_valid[r]                 = v_q[r];
   end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder (N_ROWS=4, DATA_W=8). Each vector's
// element r is 0xK0+r for vector K (A=1, B=2, ...). The expected per-cycle
// values of fifo_rd_en, sa_data, sa_valid, done and busy are hand-written.
module tb_sa_skew_feeder;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  tile_len;
   logic        fifo_empty;
   logic [31:0] fifo_data;
   logic        fifo_rd_en;
   logic        stall;
   logic [31:0] sa_data;
   logic [3:0]  sa_valid;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   string tname;
   logic [31:0] q[$];

   localparam logic [31:0] VA = 32'h13121110;
   localparam logic [31:0] VB = 32'h23222120;
   localparam logic [31:0] VC = 32'h33323130;
   localparam logic [31:0] VD = 32'h43424140;
   localparam logic [31:0] VE = 32'h53525150;

   sa_skew_feeder #(.N_ROWS(4), .DATA_W(8), .LEN_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .tile_len   (tile_len),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .stall      (stall),
      .sa_data    (sa_data),
      .sa_valid   (sa_valid),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: entered at posedge+1, drives inputs, checks outputs
   // mid-cycle, then applies the FIFO pop the DUT requested at the edge.
   task automatic step(input logic st, input logic [7:0] tl, input logic stl,
                       input logic femp, input logic e_rd, input logic [31:0] e_dat,
                       input logic [3:0] e_vld, input logic e_done, input logic e_busy);
      logic rd;
      start      = st;
      tile_len   = tl;
      stall      = stl;
      fifo_empty = femp || (q.size() == 0);
      fifo_data  = (q.size() != 0) ? q[0] : 32'h0;
      #3;
      chk($sformatf("%s c%0d rd_en", tname, cyc), {31'd0, fifo_rd_en}, {31'd0, e_rd});
      chk($sformatf("%s c%0d sa_data", tname, cyc), sa_data, e_dat);
      chk($sformatf("%s c%0d sa_valid", tname, cyc), {28'd0, sa_valid}, {28'd0, e_vld});
      chk($sformatf("%s c%0d done", tname, cyc), {31'd0, done}, {31'd0, e_done});
      chk($sformatf("%s c%0d busy", tname, cyc), {31'd0, busy}, {31'd0, e_busy});
      #5;
      rd = fifo_rd_en;
      @(posedge clk);
      if (rd && q.size() != 0) void'(q.pop_front());
      #1;
      cyc++;
   endtask

   task automatic begin_test(input string name);
      tname = name;
      cyc   = 0;
      q.delete();
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      tile_len   = 8'd0;
      stall      = 1'b0;
      fifo_empty = 1'b1;
      fifo_data  = 32'h0;
      @(posedge clk);
      #1;
      chk("reset sa_data", sa_data, 32'h0);
      chk("reset sa_valid", {28'd0, sa_valid}, 32'h0);
      chk("reset busy_done", {30'd0, busy, done}, 32'h0);
      chk("reset rd_en", {31'd0, fifo_rd_en}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Three vectors, no hazards.
      begin_test("t1");
      q.push_back(VA); q.push_back(VB); q.push_back(VC);
      step(1, 8'd3, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0);
      step(0, 8'd0, 0, 0, 1, 32'h00000000, 4'b0000, 0, 1);
      step(0, 8'd0, 0, 0, 1, 32'h00000010, 4'b0001, 0, 1);
      step(0, 8'd0, 0, 0, 1, 32'h00001120, 4'b0011, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h00122130, 4'b0111, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h13223100, 4'b1110, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h23320000, 4'b1100, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h33000000, 4'b1000, 1, 1);
      step(0, 8'd0, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0);

      // FIFO empty in cycle 2 injects a bubble.
      begin_test("t2");
      q.push_back(VA); q.push_back(VB);
      step(1, 8'd2, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0);
      step(0, 8'd0, 0, 0, 1, 32'h00000000, 4'b0000, 0, 1);
      step(0, 8'd0, 0, 1, 0, 32'h00000010, 4'b0001, 0, 1);
      step(0, 8'd0, 0, 0, 1, 32'h00001100, 4'b0010, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h00120020, 4'b0101, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h13002100, 4'b1010, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h00220000, 4'b0100, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h23000000, 4'b1000, 1, 1);
      step(0, 8'd0, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0);

      // Stall in cycles 3-4 freezes outputs and shifts everything by two.
      begin_test("t3");
      q.push_back(VA); q.push_back(VB); q.push_back(VC);
      step(1, 8'd3, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0);
      step(0, 8'd0, 0, 0, 1, 32'h00000000, 4'b0000, 0, 1);
      step(0, 8'd0, 0, 0, 1, 32'h00000010, 4'b0001, 0, 1);
      step(0, 8'd0, 1, 0, 0, 32'h00001120, 4'b0011, 0, 1);
      step(0, 8'd0, 1, 0, 0, 32'h00001120, 4'b0011, 0, 1);
      step(0, 8'd0, 0, 0, 1, 32'h00001120, 4'b0011, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h00122130, 4'b0111, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h13223100, 4'b1110, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h23320000, 4'b1100, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h33000000, 4'b1000, 1, 1);
      step(0, 8'd0, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0);

      // Zero-length tile: done without any pop.
      begin_test("t4");
      q.push_back(VA);
      step(1, 8'd0, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0);
      step(0, 8'd0, 0, 0, 0, 32'h00000000, 4'b0000, 1, 1);
      step(0, 8'd0, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0);
      chk("t4 fifo untouched", q.size(), 32'd1);

      // Reset in cycle 3 of a five-vector tile, then a clean rerun.
      begin_test("t5a");
      q.push_back(VA); q.push_back(VB); q.push_back(VC); q.push_back(VD); q.push_back(VE);
      step(1, 8'd5, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0);
      step(0, 8'd0, 0, 0, 1, 32'h00000000, 4'b0000, 0, 1);
      step(0, 8'd0, 0, 0, 1, 32'h00000010, 4'b0001, 0, 1);
      start = 1'b0;
      #1;
      chk("t5a c3 rd_en before rst", {31'd0, fifo_rd_en}, 32'd1);
      rst = 1'b1;
      #1;
      chk("t5a rst rd_en", {31'd0, fifo_rd_en}, 32'd0);
      chk("t5a rst sa_valid", {28'd0, sa_valid}, 32'd0);
      chk("t5a rst sa_data", sa_data, 32'd0);
      chk("t5a rst busy", {31'd0, busy}, 32'd0);
      chk("t5a rst done", {31'd0, done}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      begin_test("t5b");
      q.push_back(VA); q.push_back(VB); q.push_back(VC); q.push_back(VD); q.push_back(VE);
      step(1, 8'd5, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0);
      step(0, 8'd0, 0, 0, 1, 32'h00000000, 4'b0000, 0, 1);
      step(0, 8'd0, 0, 0, 1, 32'h00000010, 4'b0001, 0, 1);
      step(0, 8'd0, 0, 0, 1, 32'h00001120, 4'b0011, 0, 1);
      step(0, 8'd0, 0, 0, 1, 32'h00122130, 4'b0111, 0, 1);
      step(0, 8'd0, 0, 0, 1, 32'h13223140, 4'b1111, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h23324150, 4'b1111, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h33425100, 4'b1110, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h43520000, 4'b1100, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h53000000, 4'b1000, 1, 1);
      step(0, 8'd0, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0);

      // Second start mid-tile with a different length is ignored.
      begin_test("t6");
      q.push_back(VA); q.push_back(VB); q.push_back(VC); q.push_back(VD); q.push_back(VE);
      step(1, 8'd3, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0);
      step(0, 8'd0, 0, 0, 1, 32'h00000000, 4'b0000, 0, 1);
      step(1, 8'd7, 0, 0, 1, 32'h00000010, 4'b0001, 0, 1);
      step(0, 8'd0, 0, 0, 1, 32'h00001120, 4'b0011, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h00122130, 4'b0111, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h13223100, 4'b1110, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h23320000, 4'b1100, 0, 1);
      step(0, 8'd0, 0, 0, 0, 32'h33000000, 4'b1000, 1, 1);
      step(0, 8'd0, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0);
      step(0, 8'd0, 0, 0, 0, 32'h00000000, 4'b0000, 0, 0);
      chk("t6 vectors left", q.size(), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
